// File: rtl/dram_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : dram_arbiter                                                   |
// | Purpose : Two-master arbiter sharing one asynchronous-read DRAM port;    |
// |           accept -> access -> response pipeline, one access per cycle.  |
// | Option  : DRAM_ARB_RR_EN selects round-robin, else master 1 wins ties.   |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module dram_arbiter #(
   parameter int ADDR_BITS = 20
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 m0_req,
   input  logic [ADDR_BITS-1:0] m0_addr,
   input  logic [3:0]           m0_we,
   input  logic [31:0]          m0_wdata,
   output logic                 m0_gnt,
   output logic                 m0_rvalid,
   output logic [31:0]          m0_rdata,
   input  logic                 m1_req,
   input  logic [ADDR_BITS-1:0] m1_addr,
   input  logic [3:0]           m1_we,
   input  logic [31:0]          m1_wdata,
   output logic                 m1_gnt,
   output logic                 m1_rvalid,
   output logic [31:0]          m1_rdata,
   output logic [ADDR_BITS-1:0] dram_a,
   output logic [3:0]           dram_we,
   output logic [31:0]          dram_d,
   input  logic [31:0]          dram_spo
);

   logic                 acc_v_q,     acc_v_d;
   logic                 acc_id_q,    acc_id_d;
   logic [ADDR_BITS-1:0] acc_addr_q,  acc_addr_d;
   logic [3:0]           acc_we_q,    acc_we_d;
   logic [31:0]          acc_wdata_q, acc_wdata_d;
   logic                 rsp_v_q,     rsp_v_d;
   logic                 rsp_id_q,    rsp_id_d;
   logic [31:0]          rsp_data_q,  rsp_data_d;
   logic                 w_pick1;
   logic                 w_accept;

`ifdef DRAM_ARB_RR_EN
   logic                 rr_q, rr_d;
`endif

   // Arbitration: the only combinational input-to-output path.
   always_comb begin
      w_pick1 = m1_req;
      if (m0_req && m1_req) begin
`ifdef DRAM_ARB_RR_EN
         w_pick1 = rr_q;
`else
         w_pick1 = 1'b1;
`endif
      end
      w_accept = (m0_req || m1_req) && !rst;
      m0_gnt   = w_accept && !w_pick1;
      m1_gnt   = w_accept &&  w_pick1;
   end

   always_comb begin
      acc_v_d     = w_accept;
      acc_id_d    = acc_id_q;
      acc_addr_d  = acc_addr_q;
      acc_we_d    = acc_we_q;
      acc_wdata_d = acc_wdata_q;
      if (w_accept) begin
         acc_id_d    = w_pick1;
         acc_addr_d  = w_pick1 ? m1_addr  : m0_addr;
         acc_we_d    = w_pick1 ? m1_we    : m0_we;
         acc_wdata_d = w_pick1 ? m1_wdata : m0_wdata;
      end

      rsp_v_d    = acc_v_q;
      rsp_id_d   = rsp_id_q;
      rsp_data_d = rsp_data_q;
      if (acc_v_q) begin
         rsp_id_d   = acc_id_q;
         rsp_data_d = dram_spo;
      end
   end

`ifdef DRAM_ARB_RR_EN
   always_comb begin
      rr_d = rr_q;
      if (w_accept) begin
         rr_d = !w_pick1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_q <= 1'b0;
      end else begin
         rr_q <= rr_d;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_v_q     <= 1'b0;
         acc_id_q    <= 1'b0;
         acc_addr_q  <= '0;
         acc_we_q    <= '0;
         acc_wdata_q <= '0;
         rsp_v_q     <= 1'b0;
         rsp_id_q    <= 1'b0;
         rsp_data_q  <= '0;
      end else begin
         acc_v_q     <= acc_v_d;
         acc_id_q    <= acc_id_d;
         acc_addr_q  <= acc_addr_d;
         acc_we_q    <= acc_we_d;
         acc_wdata_q <= acc_wdata_d;
         rsp_v_q     <= rsp_v_d;
         rsp_id_q    <= rsp_id_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   // Address and data hold between accesses; only the strobes are qualified.
   always_comb begin
      dram_a    = acc_addr_q;
      dram_d    = acc_wdata_q;
      dram_we   = (acc_v_q && !rst) ? acc_we_q : 4'b0000;
      m0_rvalid = rsp_v_q && !rsp_id_q;
      m1_rvalid = rsp_v_q &&  rsp_id_q;
      m0_rdata  = rsp_data_q;
      m1_rdata  = rsp_data_q;
   end

endmodule
`default_nettype wire

// File: doc/dram_arbiter.md
# dram_arbiter

Two-master arbiter in front of the word-addressed DRAM model with byte write enables and asynchronous read. It shares the single DRAM port between master 0 (instruction fetch) and master 1 (load/store unit). It registers the winning request for one DRAM access cycle and returns a registered one-cycle response pulse to the owning master. It sits between the CPU core memory ports and the DRAM instance in the test bench top.

## Interface
- `ADDR_BITS`, 20, word-address width; must match the DRAM instance.
- `clk` input 1: single clock; all state updates on posedge.
- `rst` input 1: synchronous, active-high reset.
- `m0_req` input 1: master 0 request; held with its payload until `m0_gnt`.
- `m0_addr` input ADDR_BITS: master 0 word address.
- `m0_we` input 4: master 0 byte enables; all-zero means read.
- `m0_wdata` input 32: master 0 write data.
- `m0_gnt` output 1: combinational accept; request consumed this cycle.
- `m0_rvalid` output 1: one-cycle response pulse.
- `m0_rdata` output 32: response data, valid only with `m0_rvalid`.
- `m1_req`, `m1_addr`, `m1_we`, `m1_wdata`, `m1_gnt`, `m1_rvalid`, `m1_rdata`: same as the master 0 signals, for master 1.
- `dram_a` output ADDR_BITS: to DRAM `a`.
- `dram_we` output 4: to DRAM `we`.
- `dram_d` output 32: to DRAM `d`.
- `dram_spo` input 32: from DRAM `spo`; asynchronous read of `dram_a`.

## Operation
- Three-stage pipeline:
  - **Accept stage (cycle N).** Pick at most one requester and assert its `gnt`. Capture its addr, we and wdata, plus an owner id, into the access register. Set the access-valid flag `acc_v`.
  - **Access stage (N+1).** When `acc_v` is set, drive the access register onto `dram_a`, `dram_we` and `dram_d`. At the end of the cycle, latch `dram_spo` into the response register with the owner id and set `rsp_v`.
  - **Response stage (N+2).** `rsp_v` and the owner id drive `mX_rvalid` for exactly one cycle. `mX_rdata` carries the latched word.
- Without `acc_v`: `dram_we` = 0. `dram_a` and `dram_d` hold their last values.
- Writes also produce an `rvalid`. Its `rdata` is the word value before the write commits, because `spo` is read before the clock edge.
- Round-robin pointer `rr`, 1 bit:
  - Both masters requesting: grant master `rr`, then set `rr` to the other master.
  - Single requester: grant it immediately; `rr` := the other master.
  - No requester: `rr` holds.
- `gnt` is never asserted to a master whose `req` = 0. At most one `gnt` is high per cycle.
- Throughput is one access per cycle with no bubbles. Masters may issue back-to-back requests.
- Ordering and hazards:
  - A write accepted at N commits at the end of N+1.
  - A read of the same address accepted at N+1 accesses at N+2 and returns the new data. No forwarding is needed.
- A master that is not granted holds its request. Round-robin bounds its wait to 1 cycle.

## Timing
- Latency: request accepted at cycle N → `rvalid` at N+2, for both reads and writes.
- `gnt` depends combinationally on `req` and `rr`. No other combinational input-to-output path exists.
- Reset values: `acc_v`=0, `rsp_v`=0, `rr`=0 (master 0 favoured first), `dram_a`=0, `dram_d`=0, `mX_rdata`=0, `mX_rvalid`=0.
- Outputs forced low while `rst`=1: `m0_gnt`, `m1_gnt`, `dram_we`.
- Reset mid-operation:
  - In-flight accesses and responses are dropped.
  - `dram_we` is gated by `!rst`, so no write commits in any cycle with `rst`=1.
  - No `rvalid` appears for dropped accesses after `rst` deasserts.
- Simultaneous events:
  - Master X may receive `rvalid` for an older access in the same cycle it receives `gnt` for a new one.
  - Accept, access and response stages run concurrently on three different requests.

## Configuration
- `DRAM_ARB_RR_EN`:
  - Defined: round-robin arbitration as above.
  - Undefined: fixed priority, master 1 (load/store) always wins ties; the `rr` register is removed. Master 0 may starve while master 1 requests continuously. Single-requester behaviour and all timing are unchanged.

## Test plan
- **Reset.** Hold `rst` 3 cycles with both `req`=1. Required: no `gnt`, `dram_we`=0, all outputs at reset values. First cycle after release: `m0_gnt`=1 (rr=0).
- **Single read.** Memory word 0x10 = 0xDEADBEEF. `m1_req`, addr 0x10, we=0 at cycle N. Required: `m1_gnt` at N; `dram_a`=0x10 at N+1; `m1_rvalid`=1 with `m1_rdata`=0xDEADBEEF at N+2 only.
- **Write then read.**
  - Step 1: `m1` writes addr 0x20, we=4'b0011, wdata 0x12345678 over old value 0xAAAAAAAA. Required: `rvalid` rdata=0xAAAAAAAA.
  - Step 2: next-cycle read of 0x20. Required: 0xAAAA5678.
- **Contention** (`DRAM_ARB_RR_EN` defined). Both masters request continuously for 6 cycles. Required: grants alternate m0, m1, m0, m1, m0, m1; six `rvalid`s follow 2 cycles later in the same order.
- **Fixed priority** (`DRAM_ARB_RR_EN` undefined). Same stimulus. Required: `m1_gnt` all 6 cycles, `m0_gnt` never. After `m1_req` drops, `m0_gnt` the next cycle.
- **Reset mid-flight.** `m1` write accepted at N; assert `rst` at N+1. Required: `dram_we`=0 at N+1, the target word is unchanged, and no `m1_rvalid` follows.
